// File: rtl/line_buffer_5row_pkg.sv
// Shared constants and state encoding for the five-row line buffer.
// Row and column counters are CNT_W bits wide, so lines and frames are limited to 511.
package line_buffer_5row_pkg;

    localparam int WIDTH      = 24;
    localparam int PIC_WIDTH  = 480;
    localparam int PIC_HEIGHT = 272;
    localparam int KROWS      = 5;
    localparam int CNT_W      = 9;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } lb_state_t;

endpackage

// File: rtl/line_buffer_5row_line_delay.sv
// One line of pixel storage indexed by column.
// The old word is read and the new word is written on the same address and edge.
module line_delay
    import line_buffer_5row_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] old_data,
    output logic [DATA_W-1:0] rd_q
);

    localparam int AIW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AIW-1:0]    idx;

    assign idx = addr[AIW-1:0];

    // old_data is the pre-write content and feeds the next line in the chain,
    // which is what makes the whole chain shift by one line per write
    assign old_data = mem[idx];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (en) begin
            rd_q <= old_data;
        end
    end

endmodule

// File: rtl/line_buffer_5row.sv
// Five-row line buffer: stores the last four lines and presents one column of five
// vertically aligned pixels per accepted pixel, qualified once four rows are full.
module line_buffer_5row
    import line_buffer_5row_pkg::*;
#(
    parameter int WIDTH      = line_buffer_5row_pkg::WIDTH,
    parameter int PIC_WIDTH  = line_buffer_5row_pkg::PIC_WIDTH,
    parameter int PIC_HEIGHT = line_buffer_5row_pkg::PIC_HEIGHT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic [WIDTH-1:0] dout4,
    output logic [WIDTH-1:0] dout5,
    output logic             valid_out,
    output logic [CNT_W-1:0] col_out,
    output logic [CNT_W-1:0] row_out
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(PIC_HEIGHT - 1);
    localparam logic [CNT_W-1:0] ROW_ARM  = CNT_W'(KROWS - 2);

    logic [CNT_W-1:0] col, row;
    logic [CNT_W-1:0] pix_col, pix_row;
    logic [CNT_W-1:0] col_nxt, row_nxt;
    logic             at_line_end;
    lb_state_t        state, state_nxt;
    logic             valid_nxt;

    logic [WIDTH-1:0] old0, old1, old2, old3_unused;

    // sof retargets the pixel arriving in the same cycle to (0,0)
    always_comb begin
        pix_col     = sof ? '0 : col;
        pix_row     = sof ? '0 : row;
        at_line_end = (pix_col == COL_LAST);
        col_nxt     = col;
        row_nxt     = row;
        if (valid_in) begin
            col_nxt = at_line_end ? '0 : pix_col + 1'b1;
            if (at_line_end) begin
                row_nxt = (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
            end else begin
                row_nxt = pix_row;
            end
        end else if (sof) begin
            col_nxt = '0;
            row_nxt = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        if (sof) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL: begin
                    if (valid_in && at_line_end && pix_row == ROW_ARM) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    valid_nxt = valid_in;
                    if (valid_in && at_line_end && pix_row == ROW_LAST) begin
                        state_nxt = FILL;
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            state     <= FILL;
            valid_out <= 1'b0;
            dout5     <= '0;
            col_out   <= '0;
            row_out   <= '0;
        end else begin
            col       <= col_nxt;
            row       <= row_nxt;
            state     <= state_nxt;
            valid_out <= valid_nxt;
            if (valid_in) begin
                dout5   <= din;
                col_out <= pix_col;
                row_out <= pix_row;
            end
        end
    end

    // Each line takes the previous line's pre-write word, oldest line last
    line_delay #(.DATA_W(WIDTH), .DEPTH(PIC_WIDTH)) u_line0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (valid_in),
        .addr     (pix_col),
        .wr_data  (din),
        .old_data (old0),
        .rd_q     (dout4)
    );

    line_delay #(.DATA_W(WIDTH), .DEPTH(PIC_WIDTH)) u_line1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (valid_in),
        .addr     (pix_col),
        .wr_data  (old0),
        .old_data (old1),
        .rd_q     (dout3)
    );

    line_delay #(.DATA_W(WIDTH), .DEPTH(PIC_WIDTH)) u_line2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (valid_in),
        .addr     (pix_col),
        .wr_data  (old1),
        .old_data (old2),
        .rd_q     (dout2)
    );

    line_delay #(.DATA_W(WIDTH), .DEPTH(PIC_WIDTH)) u_line3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (valid_in),
        .addr     (pix_col),
        .wr_data  (old2),
        .old_data (old3_unused),
        .rd_q     (dout1)
    );

endmodule

// File: tb/tb_line_buffer_5row.sv
// Randomised scoreboard bench for line_buffer_5row on an 8x8 frame.
module tb_line_buffer_5row;

    localparam int W  = 24;
    localparam int PW = 8;
    localparam int PH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sof;
    logic          valid_in;
    logic [W-1:0]  din;
    logic [W-1:0]  dout1, dout2, dout3, dout4, dout5;
    logic          valid_out;
    logic [8:0]    col_out, row_out;

    typedef struct packed {
        logic [W-1:0] d1, d2, d3, d4, d5;
        logic [8:0]   c, r;
    } col_t;

    col_t         sb_q[$];
    logic [W-1:0] img [PH][PW];
    int           mrow, mcol;
    int           n_checks, n_fails;
    int           pulse_count;
    col_t         first_pulse, last_pulse;

    line_buffer_5row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof       (sof),
        .valid_in  (valid_in),
        .din       (din),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .dout4     (dout4),
        .dout5     (dout5),
        .valid_out (valid_out),
        .col_out   (col_out),
        .row_out   (row_out)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Model: a pixel at row r>=4 sees rows r-4..r-1 of the current frame at its column
    task automatic apply_stimulus(input bit v, input bit s);
        logic [W-1:0] p;
        @(negedge clk);
        if (s) begin
            mrow = 0;
            mcol = 0;
        end
        p        = {8'h00, 8'(mrow), 8'(mcol)};
        sof      = s;
        valid_in = v;
        din      = v ? p : W'($urandom);
        if (v) begin
            if (mrow >= 4) begin
                sb_q.push_back('{img[mrow-4][mcol], img[mrow-3][mcol], img[mrow-2][mcol],
                                 img[mrow-1][mcol], p, 9'(mcol), 9'(mrow)});
            end
            img[mrow][mcol] = p;
            mcol++;
            if (mcol == PW) begin
                mcol = 0;
                mrow = (mrow + 1) % PH;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_output({tag, "_valid_out"}, 32'(valid_out), 32'd0);
        check_output({tag, "_dout1"}, 32'(dout1), 32'd0);
        check_output({tag, "_dout2"}, 32'(dout2), 32'd0);
        check_output({tag, "_dout3"}, 32'(dout3), 32'd0);
        check_output({tag, "_dout4"}, 32'(dout4), 32'd0);
        check_output({tag, "_dout5"}, 32'(dout5), 32'd0);
        check_output({tag, "_col_out"}, 32'(col_out), 32'd0);
        check_output({tag, "_row_out"}, 32'(row_out), 32'd0);
    endtask

    task automatic check_first_column(input string tag);
        check_output({tag, "_first_d5"}, 32'(first_pulse.d5), 32'h000400);
        check_output({tag, "_first_d4"}, 32'(first_pulse.d4), 32'h000300);
        check_output({tag, "_first_d3"}, 32'(first_pulse.d3), 32'h000200);
        check_output({tag, "_first_d2"}, 32'(first_pulse.d2), 32'h000100);
        check_output({tag, "_first_d1"}, 32'(first_pulse.d1), 32'h000000);
    endtask

    task automatic check_last_column(input string tag);
        check_output({tag, "_last_col"}, 32'(last_pulse.c), 32'd7);
        check_output({tag, "_last_row"}, 32'(last_pulse.r), 32'd7);
        check_output({tag, "_last_d1"}, 32'(last_pulse.d1), 32'h000307);
    endtask

    // Monitor: pops on every valid_out and checks that gaps leave outputs untouched
    initial begin
        col_t cur, snap, e;
        bit   vin_edge, rst_edge;
        snap = '0;
        forever begin
            @(posedge clk);
            vin_edge = valid_in;
            rst_edge = rst_n;
            #1;
            cur = '{dout1, dout2, dout3, dout4, dout5, col_out, row_out};
            if (rst_edge && rst_n) begin
                if (valid_out) begin
                    if (sb_q.size() == 0) begin
                        check_output("unexpected_valid_out", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_output("sb_dout1", 32'(cur.d1), 32'(e.d1));
                        check_output("sb_dout2", 32'(cur.d2), 32'(e.d2));
                        check_output("sb_dout3", 32'(cur.d3), 32'(e.d3));
                        check_output("sb_dout4", 32'(cur.d4), 32'(e.d4));
                        check_output("sb_dout5", 32'(cur.d5), 32'(e.d5));
                        check_output("sb_col_out", 32'(cur.c), 32'(e.c));
                        check_output("sb_row_out", 32'(cur.r), 32'(e.r));
                        if (pulse_count == 0) first_pulse = cur;
                        last_pulse = cur;
                        pulse_count++;
                    end
                end else if (!vin_edge) begin
                    check_output("hold_outputs", 32'(cur == snap), 32'd1);
                end
            end
            snap = cur;
        end
    end

    initial begin
        int  n;
        bit  v;
        rst_n = 1'b0; sof = 1'b0; valid_in = 1'b0; din = '0;
        mrow = 0; mcol = 0; n_checks = 0; n_fails = 0; pulse_count = 0;
        first_pulse = '0; last_pulse = '0;

        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] gapless frame");
        pulse_count = 0;
        for (int i = 0; i < PW*PH; i++) apply_stimulus(1'b1, i == 0);
        idle_cycles(3);
        check_output("gapless_pulses", 32'(pulse_count), 32'((PH-4)*PW));
        check_first_column("gapless");
        check_last_column("gapless");

        $display("[TB] frame with random gaps");
        pulse_count = 0;
        n = 0;
        while (n < PW*PH) begin
            v = 1'($urandom_range(0, 1));
            apply_stimulus(v, v && n == 0);
            if (v) n++;
        end
        idle_cycles(3);
        check_output("gapped_pulses", 32'(pulse_count), 32'((PH-4)*PW));
        check_first_column("gapped");
        check_last_column("gapped");

        $display("[TB] next frame without sof, then sof mid-frame");
        pulse_count = 0;
        while (!(mrow == 5 && mcol == 3)) apply_stimulus(1'($urandom_range(0, 1)), 1'b0);
        apply_stimulus(1'b1, 1'b1);
        while (!(mrow == 6 && mcol == 2)) apply_stimulus(1'($urandom_range(0, 1)), 1'b0);
        idle_cycles(1);
        check_output("restart_pulses", 32'(pulse_count), 32'(8 + 3 + 16 + 2));
        check_output("restart_queue_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] async reset mid-frame");
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        mrow = 0; mcol = 0;
        @(negedge clk);
        rst_n = 1'b1;

        pulse_count = 0;
        for (int i = 0; i < PW*PH; i++) apply_stimulus(1'b1, i == 0);
        idle_cycles(3);
        check_output("post_reset_pulses", 32'(pulse_count), 32'((PH-4)*PW));
        check_first_column("post_reset");
        check_last_column("post_reset");
        check_output("final_queue_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/line_buffer_5row.md
Name: line_buffer_5row

Overview:
- Front end of the 5x5 window path. Takes one raster pixel stream and holds the last four image lines.
- On each accepted pixel it presents five vertically aligned pixels, one per row, from the same column. These feed the row inputs (din1..din5) of the 5x5 window/convolution stage.
- It is the producer ("writer") side of that five-row interface.

Parameters:
- WIDTH, 24, pixel width in bits ({R,G,B}, 8 bits each).
- PIC_WIDTH, 480, pixels per line. Legal range 5..511 (9-bit column counter).
- PIC_HEIGHT, 272, lines per frame. Legal range 5..511.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sof  in  1  start-of-frame pulse. Resynchronises the counters; may coincide with the first pixel.
- valid_in  in  1  pixel qualifier.
- din  in  WIDTH  raster pixel.
- dout1  out  WIDTH  pixel from row r-4 (oldest), same column.
- dout2  out  WIDTH  pixel from row r-3.
- dout3  out  WIDTH  pixel from row r-2.
- dout4  out  WIDTH  pixel from row r-1.
- dout5  out  WIDTH  current pixel, row r.
- valid_out  out  1  dout1..dout5 form a full 5-row column.
- col_out  out  9  column index of the presented column.
- row_out  out  9  row index r of dout5.

Behaviour:
- Reset (async, rst_n=0), all outputs reset:
  - dout1..dout5 = 0, valid_out = 0, col_out = 0, row_out = 0.
  - col and row counters = 0; state = FILL.
  - Line storage contents are not reset and are don't-care until refilled.
- Reset mid-frame: same result. The next frame must start with sof or from counter zero.
- Counters:
  - col increments on each valid_in and wraps PIC_WIDTH-1 -> 0.
  - On that wrap, row increments and wraps PIC_HEIGHT-1 -> 0.
  - Counters hold when valid_in=0.
- sof:
  - Forces col=0, row=0, state=FILL.
  - If sof and valid_in arrive in the same cycle, the pixel is taken as (row 0, col 0) and the next pixel is col 1.
- Storage: four line delays L0..L3, each PIC_WIDTH deep, indexed by col. On a valid_in pixel p at column c:
  - Read L0[c]..L3[c].
  - Write L0[c]<=p, L1[c]<=old L0[c], L2[c]<=old L1[c], L3[c]<=old L2[c].
  - Read-before-write within the same address and cycle is required.
- Outputs (latency 1 clock after the valid_in cycle):
  - dout5 = p, dout4 = old L0[c], dout3 = old L1[c], dout2 = old L2[c], dout1 = old L3[c].
  - col_out = c, row_out = row of p.
- Output hold: with valid_in=0, dout*, col_out and row_out hold their values and valid_out goes 0 next cycle. This matches downstream stages that only sample on valid.
- State machine:
  - FILL: valid_out stays 0. Moves to RUN when the last pixel of row 3 (col=PIC_WIDTH-1, row=3) is accepted.
  - RUN: valid_out = registered valid_in. Moves to FILL when the last pixel of row PIC_HEIGHT-1 is accepted, or on sof.
- Boundaries:
  - First valid_out is for the pixel at row 4, col 0.
  - Last valid_out in a frame is for row PIC_HEIGHT-1, col PIC_WIDTH-1.
  - Exactly (PIC_HEIGHT-4)*PIC_WIDTH valid_out pulses per frame.
  - No horizontal border handling here; the downstream window stage owns column edges.
- Throughput: one pixel per clock, no backpressure. Gaps in valid_in are allowed at any point, including across line boundaries.

Decomposition:
- Shared package:
  - Constants WIDTH, PIC_WIDTH, PIC_HEIGHT, and KROWS=5.
  - Counter width CNT_W=9.
  - State encoding: FILL=1'b0, RUN=1'b1.
- Sub-module line_delay:
  - Single-port-style RAM, WIDTH x PIC_WIDTH, with synchronous read-before-write on a shared address and an enable.
  - Instantiated four times and chained.
- The top level holds the counters, FSM and output registers.

Test Plan (PIC_WIDTH=8, PIC_HEIGHT=8 overrides, din = {8'h00, row[7:0], col[7:0]}):
- Reset then sof plus 64 continuous pixels:
  - valid_out first rises for the pixel at row 4, col 0, one cycle after that pixel is input.
  - Values then are dout5=24'h000400, dout4=24'h000300, dout3=24'h000200, dout2=24'h000100, dout1=24'h000000.
  - Exactly 32 valid_out pulses in total.
- Same frame with valid_in toggled 1-0-1 (random gaps):
  - The sequence of (dout1..dout5, col_out, row_out) on valid_out cycles is identical to the gapless run.
  - Outputs are unchanged during gaps.
- Pixel at row 7, col 7 accepted:
  - col_out=7, row_out=7, dout1=24'h000307.
  - State returns to FILL; the next frame's rows 0-3 produce no valid_out.
- sof asserted with valid_in at row 5, col 3 mid-frame: counters restart at (0,0) and no valid_out appears until the new row 4, col 0.
- rst_n pulsed low at row 6, col 2:
  - All outputs go 0 asynchronously.
  - After release, a full frame reproduces the first scenario's results.
